cla_chunk_seq: RTL
==================

# cla_chunk_seq

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by driving one CHUNK-bit carry-lookahead slice repeatedly, least-significant chunk first. It registers the inter-chunk carry between cycles. It sits between a requesting unit (ALU issue logic or testbench) and the shared CLA slice, trading latency for area. It owns operand capture, chunk selection, carry chaining, result assembly and the start/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits processed per cycle by the internal CLA slice; NCHUNK = WIDTH/CHUNK, NCHUNK >= 1

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is accepting (IDLE or DONE)
- sub  input  1  1 = a - b, 0 = a + b; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- c_in  input  1  carry-in for add; ignored when sub = 1
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- s  output  WIDTH  result; holds until the next accepted start
- c_out  output  1  carry out of bit WIDTH-1. For sub, 1 means no borrow.
- ovf  output  1  signed overflow of the final result

## Operation
- States: IDLE, RUN, DONE. A chunk counter `idx` spans 0..NCHUNK-1, with width clog2(NCHUNK), minimum 1.
- **IDLE:**
  - On start, capture A <= a and B <= (sub ? ~b : b).
  - Set carry <= (sub ? 1 : c_in) and idx <= 0.
  - Clear s, c_out and ovf to 0.
  - Go to RUN.
- **RUN, every cycle:**
  - The CLA slice computes chunk idx of A + B + carry.
  - Per bit: g = A&B and p = A^B. Lookahead carries: c[i+1] = g[i] | p[i]&c[i]. Sum bits: s = p ^ c.
  - Write the sum into s[idx*CHUNK +: CHUNK] and set carry <= slice carry-out.
  - If idx == NCHUNK-1:
    - c_out <= slice carry-out.
    - ovf <= (carry into MSB) XOR (carry out of MSB).
    - Go to DONE.
  - Otherwise idx <= idx+1.
- **DONE:**
  - done = 1 for exactly this cycle.
  - If start is asserted, capture a new request as in IDLE and go to RUN; otherwise go to IDLE.
- start during RUN is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH. c_out and ovf are defined as for a single flat WIDTH-bit adder with the same inputs.
- Intermediate chunks of s are visible while busy = 1. s is valid only from the done cycle onward.

## Timing
- **Reset** (rst high at a clock edge, in any state):
  - State goes to IDLE; idx = 0, carry = 0.
  - busy = 0, done = 0, s = 0, c_out = 0, ovf = 0.
  - An operation in progress is aborted and no done is produced.
  - rst takes priority over start.
- **Latency:** start sampled high at edge T (state IDLE) gives busy = 1 for cycles T+1..T+NCHUNK and done = 1 in cycle T+NCHUNK+1.
- **Throughput:** with start held high, one result every NCHUNK+1 cycles. A start taken in the DONE cycle moves directly to RUN; busy and done are not both high in the same cycle.
- **NCHUNK = 1:** the block still spends one RUN cycle; latency is 2.
- busy and done are registered (state-decoded), with no combinational path from start.
- Critical path is one CHUNK-bit lookahead chain plus the operand mux. It is independent of WIDTH except for the idx-indexed mux.

## Test plan
- **Carry ripple across all chunks:** WIDTH=32, CHUNK=8, a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0 -> done exactly 5 cycles after start, s=0x00000000, c_out=1, ovf=0; busy high for 4 cycles.
- **Subtract with borrow:** a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0. Then a=7, b=5, sub=1 -> s=0x00000002, c_out=1.
- **Signed overflow:** a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, ovf=1, c_out=0. Then a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, ovf=1.
- **start during RUN ignored:** pulse start with new operands 2 cycles into an operation -> exactly one done, carrying the first operation's result; no second busy period. Then back-to-back: start held through the done cycle -> next busy begins the cycle after done, second result correct.
- **Reset mid-operation:** assert rst for 1 cycle while busy -> next cycle busy=0, done=0, s=0, c_out=0, ovf=0, and no done afterwards. A following start of 3+4 -> s=7 after 5 cycles.
- **Randomized sweep:** 1000 random {a, b, sub, c_in} for (WIDTH, CHUNK) = (32,8), (16,4), (8,8) -> s, c_out and ovf match a flat reference adder; done pulse width is always 1 cycle.

Source files
------------

// File: rtl/cla_chunk_seq.sv
// Multi-cycle WIDTH-bit add/subtract built around one CHUNK-bit carry-lookahead
// slice that is reused least-significant chunk first, with the inter-chunk carry registered.
module cla_chunk_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Handshake: start is sampled only in IDLE or DONE; busy is high for the
  // RUN cycles; done is a one-cycle pulse; s/c_out/ovf hold until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, c_out_q, ovf_q;
  logic [IDXW-1:0]  idx_q;
  logic             accept;

  logic [CHUNK-1:0] a_chunk, b_chunk, g, p, sum;
  logic [CHUNK:0]   c;
  int               base;

  // One CHUNK-bit lookahead slice fed from the chunk selected by idx.
  always_comb begin
    base    = int'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    g       = a_chunk & b_chunk;
    p       = a_chunk ^ b_chunk;
    c       = '0;
    c[0]    = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p ^ c[CHUNK-1:0];
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (idx_q == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub | c_in;
        idx_q   <= '0;
        s_q     <= '0;
        c_out_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state == S_RUN) begin
        s_q[base +: CHUNK] <= sum;
        carry_q            <= c[CHUNK];
        if (idx_q == LAST_IDX) begin
          c_out_q <= c[CHUNK];
          ovf_q   <= c[CHUNK] ^ c[CHUNK-1];
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
